// File: rtl/alu_cmd_dispatcher_if.sv
// Command, ALU and result signal bundle for alu_cmd_dispatcher.
// slave = dispatcher side; master = producer/ALU/consumer side.
interface alu_cmd_dispatcher_if #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_W     = 2
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [1:0]            i_cmd_op;
  logic [DATA_WIDTH-1:0] i_cmd_a;
  logic [DATA_WIDTH-1:0] i_cmd_b;

  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic                  o_alu_add;
  logic                  o_alu_sub;
  logic                  o_alu_mul;
  logic                  o_alu_div;
  logic [DATA_WIDTH-1:0] i_alu_q;
  logic                  i_alu_ovf;
  logic                  i_alu_accept;

  logic                  o_res_valid;
  logic                  i_res_ready;
  logic [DATA_WIDTH-1:0] o_res_q;
  logic                  o_res_ovf;
  logic [1:0]            o_res_op;
  logic [ADDR_W:0]       o_level;

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_a, i_cmd_b,
    input  i_alu_q, i_alu_ovf, i_alu_accept, i_res_ready,
    output o_cmd_ready, o_alu_a, o_alu_b, o_alu_add, o_alu_sub, o_alu_mul, o_alu_div,
    output o_res_valid, o_res_q, o_res_ovf, o_res_op, o_level
  );

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_a, i_cmd_b,
    output i_alu_q, i_alu_ovf, i_alu_accept, i_res_ready,
    input  o_cmd_ready, o_alu_a, o_alu_b, o_alu_add, o_alu_sub, o_alu_mul, o_alu_div,
    input  o_res_valid, o_res_q, o_res_ovf, o_res_op, o_level
  );
endinterface

// File: rtl/alu_cmd_dispatcher.sv
// Command FIFO feeding a sequential ALU one op at a time, with a registered result stage.
// Optional macro ALU_DIV_ZERO_BYPASS_EN: answer div-by-zero locally without issuing it.
module alu_cmd_dispatcher #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2
) (
  input logic                 i_clk,
  input logic                 i_rst,
  alu_cmd_dispatcher_if.slave bus
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_t;

  logic [1:0]            r_mem_op [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_a  [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_b  [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_level;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [3:0]            r_strobe;  // {div, mul, sub, add}
  logic [1:0]            r_op;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_q;
  logic                  r_res_ovf;
  logic [1:0]            r_res_op;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic [1:0]            w_head_op;
  logic [DATA_WIDTH-1:0] w_head_a;
  logic [DATA_WIDTH-1:0] w_head_b;

  assign w_full    = (r_level == LP_DEPTH);
  assign w_push    = bus.i_cmd_valid && !w_full;
  assign w_pop     = (r_state == StIdle) && (r_level != '0) && !r_res_valid;
  assign w_head_op = r_mem_op[r_rd_ptr];
  assign w_head_a  = r_mem_a[r_rd_ptr];
  assign w_head_b  = r_mem_b[r_rd_ptr];

`ifdef ALU_DIV_ZERO_BYPASS_EN
  assign w_bypass = (w_head_op == 2'd3) && (w_head_b == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Storage needs no reset; occupancy is tracked by the pointers below.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr] <= bus.i_cmd_op;
      r_mem_a[r_wr_ptr]  <= bus.i_cmd_a;
      r_mem_b[r_wr_ptr]  <= bus.i_cmd_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_strobe    <= '0;
      r_op        <= '0;
      r_res_valid <= 1'b0;
      r_res_q     <= '0;
      r_res_ovf   <= 1'b0;
      r_res_op    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_alu_a <= w_head_a;
            r_alu_b <= w_head_b;
            r_op    <= w_head_op;
            if (w_bypass) begin
              r_res_valid <= 1'b1;
              r_res_q     <= '0;
              r_res_ovf   <= 1'b1;
              r_res_op    <= 2'd3;
              r_state     <= StDone;
            end else begin
              r_strobe <= 4'b0001 << w_head_op;
              r_state  <= StIssue;
            end
          end
        end
        StIssue: begin
          if (bus.i_alu_accept) begin
            r_res_valid <= 1'b1;
            r_res_q     <= bus.i_alu_q;
            r_res_ovf   <= bus.i_alu_ovf;
            r_res_op    <= r_op;
            r_strobe    <= '0;
            r_state     <= StDone;
          end
        end
        // Leaving via IDLE guarantees a strobes-low cycle between ops.
        StDone: begin
          if (bus.i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.o_cmd_ready = !w_full;
  assign bus.o_level     = r_level;
  assign bus.o_alu_a     = r_alu_a;
  assign bus.o_alu_b     = r_alu_b;
  assign bus.o_alu_add   = r_strobe[0];
  assign bus.o_alu_sub   = r_strobe[1];
  assign bus.o_alu_mul   = r_strobe[2];
  assign bus.o_alu_div   = r_strobe[3];
  assign bus.o_res_valid = r_res_valid;
  assign bus.o_res_q     = r_res_q;
  assign bus.o_res_ovf   = r_res_ovf;
  assign bus.o_res_op    = r_res_op;

endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// Bench for alu_cmd_dispatcher: behavioural ALU stub, expected-result queue and cycle monitors.
// Honours ALU_DIV_ZERO_BYPASS_EN for the divide-by-zero step.
module tb_alu_cmd_dispatcher;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   hold_alu = 0;
  bit   rnd_ready = 0;
  bit   div_seen = 0;
  int   alu_cnt = 0;
  logic [7:0] exp_q[$];  // {op, ovf, q} in completion order

  alu_cmd_dispatcher_if #(.DATA_WIDTH(5), .ADDR_W(2)) bus ();

  alu_cmd_dispatcher #(.DATA_WIDTH(5), .DEPTH(4), .ADDR_W(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed 5-bit ALU behaviour: {ovf, q}. Divide by zero reports overflow with q=0.
  function automatic logic [5:0] model(input logic [1:0] op, input logic signed [4:0] a,
                                       input logic signed [4:0] b);
    int ia = a;
    int ib = b;
    int r;
    case (op)
      2'd0:    r = ia + ib;
      2'd1:    r = ia - ib;
      2'd2:    r = ia * ib;
      default: begin
        if (ib == 0) return 6'b100000;
        r = ia / ib;
      end
    endcase
    return {(r > 15) || (r < -16), r[4:0]};
  endfunction

  // ALU stub: random accept latency while a strobe is up, spurious accepts otherwise.
  always @(posedge clk) begin
    logic [1:0] sop;
    logic [5:0] res;
    #1;
    if (rst || hold_alu) begin
      bus.i_alu_accept = 1'b0;
    end else if ({bus.o_alu_div, bus.o_alu_mul, bus.o_alu_sub, bus.o_alu_add} != 4'b0) begin
      if (alu_cnt == 0) begin
        sop = bus.o_alu_add ? 2'd0 : bus.o_alu_sub ? 2'd1 : bus.o_alu_mul ? 2'd2 : 2'd3;
        res = model(sop, bus.o_alu_a, bus.o_alu_b);
        bus.i_alu_accept = 1'b1;
        bus.i_alu_q      = res[4:0];
        bus.i_alu_ovf    = res[5];
      end else begin
        alu_cnt--;
        bus.i_alu_accept = 1'b0;
      end
    end else begin
      bus.i_alu_accept = ($urandom_range(0, 3) == 0);
      bus.i_alu_q      = 5'($urandom);
      bus.i_alu_ovf    = 1'($urandom);
      alu_cnt          = $urandom_range(0, 3);
    end
  end

  // Per-cycle monitor and scoreboard, sampled on the falling edge.
  logic       prev_acc = 0;
  logic       prev_hold = 0;
  logic [7:0] prev_res;
  always @(negedge clk) begin
    logic [3:0] stb;
    logic [7:0] e;
    stb = {bus.o_alu_div, bus.o_alu_mul, bus.o_alu_sub, bus.o_alu_add};
    if (!rst) begin
      check("strobe_onehot0", 32'($onehot0(stb)), 1);
      if (bus.o_res_valid) check("no_strobe_while_valid", stb, 0);
      if (prev_acc) check("turnaround_gap", stb, 0);
      if (prev_hold) begin
        check("hold_valid", bus.o_res_valid, 1);
        check("hold_result", {bus.o_res_op, bus.o_res_ovf, bus.o_res_q}, prev_res);
      end
      if (bus.o_alu_div) div_seen = 1;
      if (bus.o_res_valid && bus.i_res_ready) begin
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_q", bus.o_res_q, e[4:0]);
          check("res_ovf", bus.o_res_ovf, e[5]);
          check("res_op", bus.o_res_op, e[7:6]);
        end
      end
      prev_acc  = (stb != 4'b0) && bus.i_alu_accept;
      prev_hold = bus.o_res_valid && !bus.i_res_ready;
      prev_res  = {bus.o_res_op, bus.o_res_ovf, bus.o_res_q};
    end else begin
      prev_acc  = 0;
      prev_hold = 0;
    end
  end

  task automatic push(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    int  n = 0;
    bit  taken = 0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = op;
    bus.i_cmd_a     = a;
    bus.i_cmd_b     = b;
    if (rnd_ready) bus.i_res_ready = 1'($urandom);
    while (!taken && n < 300) begin
      @(negedge clk);
      taken = bus.o_cmd_ready;
      @(posedge clk);
      #1;
      n++;
      if (rnd_ready) bus.i_res_ready = 1'($urandom);
    end
    bus.i_cmd_valid = 1'b0;
    check("push_taken", taken, 1);
    if (taken) exp_q.push_back({op, model(op, a, b)});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.i_res_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.o_res_valid || bus.o_level != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n < 400, 1);
  endtask

  task automatic rnd_push();
    push(2'($urandom), 5'($urandom), 5'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = '0;
    bus.i_cmd_a     = '0;
    bus.i_cmd_b     = '0;
    bus.i_res_ready = 1'b1;
    bus.i_alu_accept = 1'b0;
    bus.i_alu_q     = '0;
    bus.i_alu_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", bus.o_level, 0);
    check("rst_cmd_ready", bus.o_cmd_ready, 1);
    check("rst_res_valid", bus.o_res_valid, 0);
    check("rst_strobes", {bus.o_alu_div, bus.o_alu_mul, bus.o_alu_sub, bus.o_alu_add}, 0);
    check("rst_res", {bus.o_res_op, bus.o_res_ovf, bus.o_res_q}, 0);
    check("rst_alu_ab", {bus.o_alu_a, bus.o_alu_b}, 0);
    rst = 1'b0;

    // add(1,1): strobe one edge after the push edge
    push(2'd0, 5'd1, 5'd1);
    @(posedge clk);
    #1;
    check("add_strobe", bus.o_alu_add, 1);
    check("add_alu_a", bus.o_alu_a, 1);
    check("add_alu_b", bus.o_alu_b, 1);
    check("add_level", bus.o_level, 0);
    drain("drain_add");
    check("level_after_add", bus.o_level, 0);

    // back-to-back identical ops
    push(2'd2, 5'd7, 5'd7);
    push(2'd2, 5'($signed(-7)), 5'($signed(-7)));
    drain("drain_mul");

    // consumer stalled: fill FIFO behind a held result
    bus.i_res_ready = 1'b0;
    repeat (5) rnd_push();
    check("full_level", bus.o_level, 4);
    check("full_cmd_ready", bus.o_cmd_ready, 0);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = 2'd1;
    bus.i_cmd_a     = 5'd3;
    bus.i_cmd_b     = 5'd9;
    repeat (3) begin
      @(negedge clk);
      check("refused_level", bus.o_level, 4);
      check("refused_ready", bus.o_cmd_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.i_res_ready = 1'b1;
    push(2'd1, 5'd3, 5'd9);
    drain("drain_full");

    // FIFO order across op types
    push(2'd3, 5'd10, 5'd2);
    push(2'd1, 5'd1, 5'd1);
    drain("drain_div_sub");

    // divide by zero
    div_seen = 0;
    push(2'd3, 5'd10, 5'd0);
    @(posedge clk);
    #1;
`ifdef ALU_DIV_ZERO_BYPASS_EN
    check("div0_valid_next_edge", bus.o_res_valid, 1);
    check("div0_no_strobe", bus.o_alu_div, 0);
    drain("drain_div0");
    check("div0_strobe_seen", div_seen, 0);
`else
    check("div0_strobe", bus.o_alu_div, 1);
    drain("drain_div0");
    check("div0_strobe_seen", div_seen, 1);
`endif

    // randomized traffic with a random consumer
    rnd_ready = 1;
    repeat (24) rnd_push();
    rnd_ready = 0;
    drain("drain_random");

    // reset while an op is in flight with two queued
    hold_alu = 1;
    push(2'($urandom_range(0, 2)), 5'($urandom), 5'($urandom));
    rnd_push();
    rnd_push();
    check("pre_rst_level", bus.o_level, 2);
    check("pre_rst_issue", {bus.o_alu_div, bus.o_alu_mul, bus.o_alu_sub, bus.o_alu_add} != 0, 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold_alu = 0;
    check("mid_rst_strobes", {bus.o_alu_div, bus.o_alu_mul, bus.o_alu_sub, bus.o_alu_add}, 0);
    check("mid_rst_level", bus.o_level, 0);
    check("mid_rst_valid", bus.o_res_valid, 0);
    check("mid_rst_ready", bus.o_cmd_ready, 1);
    repeat (15) @(posedge clk);
    #1;
    check("no_stale_valid", bus.o_res_valid, 0);

    push(2'd0, 5'd4, 5'd5);
    drain("drain_final");
    check("final_level", bus.o_level, 0);
    check("final_cmd_ready", bus.o_cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
